hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage core. It decides each cycle which pipeline registers advance, hold or take a bubble, based on load-use hazards and taken branches from the decode stage, instruction-fetch readiness, and data-memory completion. It also drives the PC redirect, including a branch that resolves while a fetch is still outstanding, and keeps stall and redirect counters for performance debug. It sits beside the pipeline and drives PC, fs_ds, ds_es, es_ms and ms_ws register controls.

---
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: decides advance/hold/bubble for each pipeline
// register, drives the PC redirect, and keeps stall/redirect performance counters.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [32:0] ds_branch_data,
    input  logic        ds_load_use,
    input  logic        if_ready,
    input  logic        ms_mem_req,
    input  logic        ms_mem_done,
    output logic        pc_we,
    output logic        npc_redir,
    output logic [31:0] npc_addr,
    output logic        fs_ds_we,
    output logic        ds_es_we,
    output logic        es_ms_we,
    output logic        ms_ws_we,
    output logic        fs_ds_flush,
    output logic        ds_es_flush,
    output logic        ms_ws_flush,
    output logic [31:0] stall_cnt,
    output logic [31:0] redir_cnt
);

    localparam logic [0:0] RUN        = 1'b0;
    localparam logic [0:0] REDIR_WAIT = 1'b1;

    logic [0:0]  state;
    logic [0:0]  next_state;
    logic [31:0] redir_addr;
    logic        load_redir;
    logic        use_redir_addr;

    logic [31:0] br_target;
    logic        br_taken;
    logic        dmem_stall;

    assign br_target  = ds_branch_data[32:1];
    assign br_taken   = ds_branch_data[0];
    assign dmem_stall = ms_mem_req & ~ms_mem_done;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        pc_we          = 1'b1;
        npc_redir      = 1'b0;
        fs_ds_we       = 1'b1;
        ds_es_we       = 1'b1;
        es_ms_we       = 1'b1;
        ms_ws_we       = 1'b1;
        fs_ds_flush    = 1'b0;
        ds_es_flush    = 1'b0;
        ms_ws_flush    = 1'b0;
        next_state     = state;
        load_redir     = 1'b0;
        use_redir_addr = 1'b0;

        if (rst) begin
            pc_we       = 1'b0;
            fs_ds_we    = 1'b0;
            ds_es_we    = 1'b0;
            es_ms_we    = 1'b0;
            ms_ws_we    = 1'b0;
            fs_ds_flush = 1'b1;
            ds_es_flush = 1'b1;
            ms_ws_flush = 1'b1;
        end else if (dmem_stall) begin
            // Whole front end freezes; decode is re-evaluated once memory completes.
            pc_we       = 1'b0;
            fs_ds_we    = 1'b0;
            ds_es_we    = 1'b0;
            es_ms_we    = 1'b0;
            ms_ws_flush = 1'b1;
        end else if (ds_load_use) begin
            // Branch operands are not forwarded yet, so a taken flag here is not trusted.
            pc_we       = 1'b0;
            fs_ds_we    = 1'b0;
            ds_es_flush = 1'b1;
        end else if (state == REDIR_WAIT) begin
            fs_ds_flush = 1'b1;
            if (if_ready) begin
                npc_redir      = 1'b1;
                use_redir_addr = 1'b1;
                next_state     = RUN;
            end else begin
                pc_we = 1'b0;
            end
        end else if (br_taken) begin
            fs_ds_flush = 1'b1;
            if (if_ready) begin
                npc_redir = 1'b1;
            end else begin
                // Fetch still outstanding: remember the target and redirect once it lands.
                pc_we      = 1'b0;
                load_redir = 1'b1;
                next_state = REDIR_WAIT;
            end
        end else if (!if_ready) begin
            pc_we       = 1'b0;
            fs_ds_flush = 1'b1;
        end
    end

    assign npc_addr = use_redir_addr ? redir_addr : br_target;

    // NOTE: registered state uses non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            redir_addr <= 32'h0;
            stall_cnt  <= 32'h0;
            redir_cnt  <= 32'h0;
        end else begin
            state <= next_state;
            if (load_redir) begin
                redir_addr <= br_target;
            end
            if (!pc_we) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (pc_we && npc_redir) begin
                redir_cnt <= redir_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: the driver queues hand-computed expectations,
// a monitor process pops and compares them against the DUT each cycle.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [32:0] ds_branch_data = 33'h0;
    logic        ds_load_use = 1'b0;
    logic        if_ready = 1'b0;
    logic        ms_mem_req = 1'b0;
    logic        ms_mem_done = 1'b0;
    logic        pc_we, npc_redir;
    logic [31:0] npc_addr;
    logic        fs_ds_we, ds_es_we, es_ms_we, ms_ws_we;
    logic        fs_ds_flush, ds_es_flush, ms_ws_flush;
    logic [31:0] stall_cnt, redir_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .ds_branch_data (ds_branch_data),
        .ds_load_use    (ds_load_use),
        .if_ready       (if_ready),
        .ms_mem_req     (ms_mem_req),
        .ms_mem_done    (ms_mem_done),
        .pc_we          (pc_we),
        .npc_redir      (npc_redir),
        .npc_addr       (npc_addr),
        .fs_ds_we       (fs_ds_we),
        .ds_es_we       (ds_es_we),
        .es_ms_we       (es_ms_we),
        .ms_ws_we       (ms_ws_we),
        .fs_ds_flush    (fs_ds_flush),
        .ds_es_flush    (ds_es_flush),
        .ms_ws_flush    (ms_ws_flush),
        .stall_cnt      (stall_cnt),
        .redir_cnt      (redir_cnt)
    );

    // Control bits: {pc_we, npc_redir, fs_ds_we, ds_es_we, es_ms_we, ms_ws_we,
    //                fs_ds_flush, ds_es_flush, ms_ws_flush}
    localparam logic [8:0] C_RST   = 9'b0_0_0000_111;
    localparam logic [8:0] C_RUN   = 9'b1_0_1111_000;
    localparam logic [8:0] C_LU    = 9'b0_0_0111_010;
    localparam logic [8:0] C_REDIR = 9'b1_1_1111_100;
    localparam logic [8:0] C_FMISS = 9'b0_0_1111_100;
    localparam logic [8:0] C_DMEM  = 9'b0_0_0001_001;

    typedef struct {
        string       name;
        logic [8:0]  ctrl;
        logic        chk_addr;
        logic [31:0] addr;
        logic [31:0] stall;
        logic [31:0] redir;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    // Drive one cycle of stimulus just after the rising edge and queue its expectation.
    task automatic step(input string name, input logic r, input logic [31:0] tgt, input logic tk,
                        input logic lu, input logic ifr, input logic req, input logic done,
                        input logic [8:0] ctrl, input logic chk_addr, input logic [31:0] addr,
                        input logic [31:0] stall, input logic [31:0] redir);
        exp_t e;
        @(posedge clk);
        #1;
        rst            = r;
        ds_branch_data = {tgt, tk};
        ds_load_use    = lu;
        if_ready       = ifr;
        ms_mem_req     = req;
        ms_mem_done    = done;
        e.name = name; e.ctrl = ctrl; e.chk_addr = chk_addr;
        e.addr = addr; e.stall = stall; e.redir = redir;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".ctrl"},
                      {23'h0, pc_we, npc_redir, fs_ds_we, ds_es_we, es_ms_we, ms_ws_we,
                       fs_ds_flush, ds_es_flush, ms_ws_flush}, {23'h0, e.ctrl});
                if (e.chk_addr) check({e.name, ".npc_addr"}, npc_addr, e.addr);
                check({e.name, ".stall_cnt"}, stall_cnt, e.stall);
                check({e.name, ".redir_cnt"}, redir_cnt, e.redir);
            end
        end
    end

    initial begin : driver
        int guard;
        //    name           rst tgt        tk lu if rq dn ctrl     ca addr        stall redir
        step("rst0",         1, 32'h100,    1, 0, 1, 0, 0, C_RST,   0, 32'h0,      0,  0);
        step("rst1",         1, 32'h100,    1, 0, 1, 0, 0, C_RST,   0, 32'h0,      0,  0);
        step("run0",         0, 32'h0,      0, 0, 1, 0, 0, C_RUN,   0, 32'h0,      0,  0);
        step("run1",         0, 32'h0,      0, 0, 1, 0, 0, C_RUN,   0, 32'h0,      0,  0);
        step("lu",           0, 32'h0,      0, 1, 1, 0, 0, C_LU,    0, 32'h0,      0,  0);
        step("lu_after",     0, 32'h0,      0, 0, 1, 0, 0, C_RUN,   0, 32'h0,      1,  0);
        step("br_ready",     0, 32'h100,    1, 0, 1, 0, 0, C_REDIR, 1, 32'h100,    1,  0);
        step("br_after",     0, 32'h0,      0, 0, 1, 0, 0, C_RUN,   0, 32'h0,      1,  1);
        step("rst_hold",     1, 32'h0,      0, 0, 1, 0, 0, C_RST,   0, 32'h0,      1,  1);
        step("rst_clear",    0, 32'h0,      0, 0, 1, 0, 0, C_RUN,   0, 32'h0,      0,  0);
        step("miss_br",      0, 32'h200,    1, 0, 0, 0, 0, C_FMISS, 0, 32'h0,      0,  0);
        step("miss_w1",      0, 32'h0,      0, 0, 0, 0, 0, C_FMISS, 0, 32'h0,      1,  0);
        step("miss_w2",      0, 32'h0,      0, 0, 0, 0, 0, C_FMISS, 0, 32'h0,      2,  0);
        step("miss_w3",      0, 32'h0,      0, 0, 0, 0, 0, C_FMISS, 0, 32'h0,      3,  0);
        step("miss_redir",   0, 32'h0,      0, 0, 1, 0, 0, C_REDIR, 1, 32'h200,    4,  0);
        step("miss_run",     0, 32'h55,     0, 0, 1, 0, 0, C_RUN,   1, 32'h55,     4,  1);
        step("dm_br",        0, 32'h300,    1, 0, 0, 0, 0, C_FMISS, 0, 32'h0,      4,  1);
        step("dm_stall1",    0, 32'h0,      0, 0, 1, 1, 0, C_DMEM,  0, 32'h0,      5,  1);
        step("dm_stall2",    0, 32'h0,      0, 0, 1, 1, 0, C_DMEM,  0, 32'h0,      6,  1);
        step("dm_release",   0, 32'h0,      0, 0, 1, 1, 1, C_REDIR, 1, 32'h300,    7,  1);
        step("dm_after",     0, 32'h0,      0, 0, 1, 0, 0, C_RUN,   0, 32'h0,      7,  2);
        step("prio_lu_br",   0, 32'h400,    1, 1, 1, 0, 0, C_LU,    0, 32'h0,      7,  2);
        step("prio_after",   0, 32'h0,      0, 0, 1, 0, 0, C_RUN,   0, 32'h0,      8,  2);
        step("prio_dm_br",   0, 32'h480,    1, 0, 1, 1, 0, C_DMEM,  0, 32'h0,      8,  2);
        step("prio_dm_aft",  0, 32'h0,      0, 0, 1, 0, 0, C_RUN,   0, 32'h0,      9,  2);
        step("fetch_miss",   0, 32'h0,      0, 0, 0, 0, 0, C_FMISS, 0, 32'h0,      9,  2);
        step("fetch_after",  0, 32'h0,      0, 0, 1, 0, 0, C_RUN,   0, 32'h0,     10,  2);
        step("rw_br",        0, 32'h500,    1, 0, 0, 0, 0, C_FMISS, 0, 32'h0,     10,  2);
        step("rw_rst",       1, 32'h0,      0, 0, 1, 0, 0, C_RST,   0, 32'h0,     11,  2);
        step("rw_discard",   0, 32'h0,      0, 0, 1, 0, 0, C_RUN,   1, 32'h0,      0,  0);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain: pending=%0d want=0", exp_q.size());
        end
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
